data_mem_hs: RTL and testbench
==============================

# data_mem_hs

Parametrised handshaked data memory for the single-cycle CPU datapath. It generalises the base+offset data memory: width, depth and init value are parametrised, and a hardware init sweep replaces file preload. Reads are registered with valid/ready flow control, and address wrap-around is flagged. It sits between the execute stage (load/store requests) and writeback (load data).

## Interface
- W, 8, data width in bits
- A, 8, address width; depth = 2**A words
- INIT_VAL, 0, W-bit value written to every word during the init sweep
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- ReqValid  input  1  request present this cycle
- ReqReady  output  1  request accepted when ReqValid && ReqReady
- WriteEn  input  1  1 = store, 0 = load; sampled with request
- DataAddress  input  A  base address (2nd operand)
- Offset  input  A  offset (3rd operand)
- DataIn  input  W  store data
- RespValid  output  1  load data valid on DataOut
- RespReady  input  1  consumer takes response when RespValid && RespReady
- DataOut  output  W  registered load data
- AddrWrap  output  1  qualifies DataOut: effective address overflowed 2**A
- InitDone  output  1  init sweep complete

## Operation
- Effective address EA = (DataAddress + Offset) mod 2**A. The carry out of the A-bit sum is the wrap bit.
- States:
  - INIT: counter sweeps 0..2**A-1, writing INIT_VAL one word per cycle. On the last word the block goes to RUN.
  - RUN: serves requests.
- Reset, including mid-sweep or mid-response, forces INIT with counter = 0. Any pending response is discarded.
- ReqReady = (state==RUN) && !(RespValid && !RespReady).
- Store accepted: Core[EA] <= DataIn at that edge. No response is generated.
- Load accepted: DataOut <= Core[EA], AddrWrap <= carry, RespValid <= 1 at that edge.
- RespValid clears when RespReady is high and no new load is accepted in the same cycle. If a load is accepted that cycle, the new response replaces the old one.
- While RespValid && !RespReady: DataOut and AddrWrap hold stable and ReqReady = 0, so loads and stores both stall.
- Requests with ReqValid && !ReqReady are ignored. The requester holds them.

## Timing
- Reset values:
  - ReqReady 0
  - RespValid 0
  - DataOut 0
  - AddrWrap 0
  - InitDone 0
- Init sweep takes exactly 2**A cycles after the Reset cycle.
  - InitDone and ReqReady rise in the cycle after the last init write.
  - InitDone stays 1 until the next Reset.
- Load latency is 1 cycle: request accepted at edge N, RespValid/DataOut valid from edge N through edge N+1.
- Throughput is one request per cycle while RespReady = 1.
- Store then load to the same EA on consecutive cycles returns the new data; no forwarding logic is required.
- A store and a load never coincide, since there is one request port.

## Structure
- Package data_mem_pkg:
  - state enum typedef {INIT, RUN}
  - default W/A constants
- One sub-module, mem_array: a 2**A x W storage array with one synchronous write port and one combinational read port.
- The FSM, init counter, EA adder, handshake and response registers live in data_mem_hs.
- The init write muxes into mem_array's write port in INIT.

## Test plan
- Reset held 1 cycle with INIT_VAL=8'h5A, then wait -> InitDone rises exactly 256 cycles later. A load of address 8'h00 and a load of 8'hFF both return 8'h5A.
- Store DataIn=8'hC3 at DataAddress=8'h10, Offset=8'h05, then next-cycle load 8'h15/0 -> DataOut=8'hC3, RespValid for 1 cycle, AddrWrap=0.
- Load DataAddress=8'hF0, Offset=8'h20 after storing 8'h77 at 8'h10 -> DataOut=8'h77, AddrWrap=1.
- Load with RespReady=0 for 3 cycles while ReqValid stays high -> ReqReady=0, DataOut stable for 3 cycles. The next request is accepted in the cycle RespReady=1.
- Back-to-back loads of 8'h01, 8'h02, 8'h03 with RespReady=1 -> three consecutive RespValid cycles with the matching data.
- Reset asserted at sweep count 100 and while RespValid=1 -> RespValid drops next cycle, the sweep restarts from 0, and InitDone rises 256 cycles after Reset.

Source files
------------

// File: rtl/data_mem_hs_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared types and default constants for the handshaked data memory.
//   state_t      : controller state (INIT sweep / RUN serving requests)
//   DATA_W_DEF   : default data width in bits
//   ADDR_W_DEF   : default address width (depth = 2**ADDR_W_DEF words)
// ---------------------------------------------------------------------------
package data_mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/data_mem_hs_if.sv
// ---------------------------------------------------------------------------
// data_mem_hs_if
// Request/response bundle between the execute stage (master) and the data
// memory (slave).
//   ReqValid/ReqReady   : request handshake
//   WriteEn             : 1 = store, 0 = load
//   DataAddress, Offset : base and offset, summed into the effective address
//   DataIn              : store data
//   RespValid/RespReady : load-response handshake
//   DataOut, AddrWrap   : registered load data and wrap flag
//   InitDone            : init sweep finished
// ---------------------------------------------------------------------------
interface data_mem_hs_if #(
    parameter int W = data_mem_pkg::DATA_W_DEF,
    parameter int A = data_mem_pkg::ADDR_W_DEF
);
    logic         ReqValid;
    logic         ReqReady;
    logic         WriteEn;
    logic [A-1:0] DataAddress;
    logic [A-1:0] Offset;
    logic [W-1:0] DataIn;
    logic         RespValid;
    logic         RespReady;
    logic [W-1:0] DataOut;
    logic         AddrWrap;
    logic         InitDone;

    modport master (
        output ReqValid, WriteEn, DataAddress, Offset, DataIn, RespReady,
        input  ReqReady, RespValid, DataOut, AddrWrap, InitDone
    );

    modport slave (
        input  ReqValid, WriteEn, DataAddress, Offset, DataIn, RespReady,
        output ReqReady, RespValid, DataOut, AddrWrap, InitDone
    );
endinterface

// File: rtl/data_mem_hs_mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// 2**A x W storage with one synchronous write port and one combinational
// read port. No reset: contents are established by the controller's sweep.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// ---------------------------------------------------------------------------
module mem_array #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         i_clk,
    input  logic         i_we,
    input  logic [A-1:0] i_waddr,
    input  logic [W-1:0] i_wdata,
    input  logic [A-1:0] i_raddr,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_mem [2**A];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_hs.sv
// ---------------------------------------------------------------------------
// data_mem_hs
// Handshaked data memory. After reset it sweeps every word to INIT_VAL, then
// serves loads/stores at EA = DataAddress + Offset (mod 2**A). Loads return
// registered data one edge after acceptance, together with the carry out of
// the address sum (AddrWrap). A response that is not yet taken stalls all
// further requests.
//   i_Clk   : clock, rising edge
//   i_Reset : synchronous active-high reset
//   bus     : data_mem_hs_if slave port (request/response handshake)
// ---------------------------------------------------------------------------
module data_mem_hs
    import data_mem_pkg::*;
#(
    parameter int           W        = DATA_W_DEF,
    parameter int           A        = ADDR_W_DEF,
    parameter logic [W-1:0] INIT_VAL = '0
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    data_mem_hs_if.slave bus
);

    state_t       r_state;
    logic [A-1:0] r_initCnt;
    logic         r_respValid;
    logic [W-1:0] r_dataOut;
    logic         r_addrWrap;
    logic         r_initDone;

    logic [A:0]   w_sum;
    logic [A-1:0] w_ea;
    logic         w_carry;
    logic         w_reqReady;
    logic         w_accept;
    logic         w_we;
    logic [A-1:0] w_waddr;
    logic [W-1:0] w_wdata;
    logic [W-1:0] w_rdata;

    // Extra MSB on the sum captures the wrap-around carry.
    assign w_sum   = {1'b0, bus.DataAddress} + {1'b0, bus.Offset};
    assign w_ea    = w_sum[A-1:0];
    assign w_carry = w_sum[A];

    // A response still waiting for its consumer blocks every new request.
    assign w_reqReady = (r_state == RUN) && !(r_respValid && !bus.RespReady);
    assign w_accept   = bus.ReqValid && w_reqReady;

    // During the sweep the init counter owns the write port.
    assign w_we    = (r_state == INIT) || (w_accept && bus.WriteEn);
    assign w_waddr = (r_state == INIT) ? r_initCnt : w_ea;
    assign w_wdata = (r_state == INIT) ? INIT_VAL : bus.DataIn;

    mem_array #(
        .W(W),
        .A(A)
    ) u_memArray (
        .i_clk  (i_Clk),
        .i_we   (w_we),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_raddr(w_ea),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= INIT;
            r_initCnt   <= '0;
            r_respValid <= 1'b0;
            r_dataOut   <= '0;
            r_addrWrap  <= 1'b0;
            r_initDone  <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_initCnt <= r_initCnt + 1'b1;
                    if (r_initCnt == {A{1'b1}}) begin
                        r_state    <= RUN;
                        r_initDone <= 1'b1;
                    end
                end
                RUN: begin
                    // A newly accepted load overrides clearing the old one.
                    if (w_accept && !bus.WriteEn) begin
                        r_respValid <= 1'b1;
                        r_dataOut   <= w_rdata;
                        r_addrWrap  <= w_carry;
                    end else if (bus.RespReady) begin
                        r_respValid <= 1'b0;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.ReqReady  = w_reqReady;
    assign bus.RespValid = r_respValid;
    assign bus.DataOut   = r_dataOut;
    assign bus.AddrWrap  = r_addrWrap;
    assign bus.InitDone  = r_initDone;

endmodule

// File: tb/tb_data_mem_hs.sv
// ---------------------------------------------------------------------------
// tb_data_mem_hs
// Directed bench for data_mem_hs (W=8, A=8, INIT_VAL=8'h5A). Inputs change
// 1 time unit after each rising edge; registered outputs are examined there,
// and ReqReady one more unit later once new inputs have settled.
// ---------------------------------------------------------------------------
module tb_data_mem_hs;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    data_mem_hs_if #(.W(8), .A(8)) bus ();

    data_mem_hs #(
        .W(8),
        .A(8),
        .INIT_VAL(8'h5A)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(reset),
        .bus    (bus)
    );

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one request/response-side input vector, then let it settle.
    task automatic applyStimulus(input logic valid, input logic we,
                                 input logic [7:0] addr, input logic [7:0] off,
                                 input logic [7:0] din, input logic respReady);
        bus.ReqValid    = valid;
        bus.WriteEn     = we;
        bus.DataAddress = addr;
        bus.Offset      = off;
        bus.DataIn      = din;
        bus.RespReady   = respReady;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until InitDone rises, bounded to 300.
    task automatic waitInitDone(output int cycles);
        cycles = 301;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (bus.InitDone === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 0);

        // Reset state
        tick();
        checkOutput("rst_ReqReady", 16'(bus.ReqReady), 16'h0);
        checkOutput("rst_RespValid", 16'(bus.RespValid), 16'h0);
        checkOutput("rst_DataOut", 16'(bus.DataOut), 16'h00);
        checkOutput("rst_AddrWrap", 16'(bus.AddrWrap), 16'h0);
        checkOutput("rst_InitDone", 16'(bus.InitDone), 16'h0);
        reset = 1'b0;

        // Init sweep length
        waitInitDone(n);
        checkOutput("init_cycles", 16'(n), 16'd256);
        checkOutput("init_ReqReady", 16'(bus.ReqReady), 16'h1);

        // Loads of the lowest and highest word after the sweep
        applyStimulus(1, 0, 8'h00, 8'h00, 8'h00, 1);
        tick();
        checkOutput("ld00_valid", 16'(bus.RespValid), 16'h1);
        checkOutput("ld00_data", 16'(bus.DataOut), 16'h5A);
        applyStimulus(1, 0, 8'hFF, 8'h00, 8'h00, 1);
        tick();
        checkOutput("ldFF_valid", 16'(bus.RespValid), 16'h1);
        checkOutput("ldFF_data", 16'(bus.DataOut), 16'h5A);
        checkOutput("ldFF_wrap", 16'(bus.AddrWrap), 16'h0);
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 1);
        tick();
        checkOutput("idle_valid", 16'(bus.RespValid), 16'h0);

        // Store at 10+05, then load 15+00 on the next cycle
        applyStimulus(1, 1, 8'h10, 8'h05, 8'hC3, 1);
        tick();
        checkOutput("st15_novalid", 16'(bus.RespValid), 16'h0);
        applyStimulus(1, 0, 8'h15, 8'h00, 8'h00, 1);
        tick();
        checkOutput("ld15_valid", 16'(bus.RespValid), 16'h1);
        checkOutput("ld15_data", 16'(bus.DataOut), 16'hC3);
        checkOutput("ld15_wrap", 16'(bus.AddrWrap), 16'h0);
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 1);
        tick();
        checkOutput("ld15_onecycle", 16'(bus.RespValid), 16'h0);

        // Store 77 at 10, then wrapping load F0+20 -> EA 10
        applyStimulus(1, 1, 8'h10, 8'h00, 8'h77, 1);
        tick();
        applyStimulus(1, 0, 8'hF0, 8'h20, 8'h00, 1);
        tick();
        checkOutput("wrap_data", 16'(bus.DataOut), 16'h77);
        checkOutput("wrap_flag", 16'(bus.AddrWrap), 16'h1);
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 1);
        tick();

        // Backpressure: response held for 3 cycles, requester keeps asking
        applyStimulus(1, 0, 8'h15, 8'h00, 8'h00, 0);
        checkOutput("bp_ready_before", 16'(bus.ReqReady), 16'h1);
        tick();
        applyStimulus(1, 0, 8'h10, 8'h00, 8'h00, 0);
        checkOutput("bp_ready_stall", 16'(bus.ReqReady), 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_data_hold", 16'(bus.DataOut), 16'hC3);
            checkOutput("bp_valid_hold", 16'(bus.RespValid), 16'h1);
            checkOutput("bp_ready_low", 16'(bus.ReqReady), 16'h0);
        end
        applyStimulus(1, 0, 8'h10, 8'h00, 8'h00, 1);
        checkOutput("bp_ready_release", 16'(bus.ReqReady), 16'h1);
        tick();
        checkOutput("bp_next_data", 16'(bus.DataOut), 16'h77);
        checkOutput("bp_next_valid", 16'(bus.RespValid), 16'h1);

        // Back-to-back loads of distinct words 01..03
        applyStimulus(1, 1, 8'h01, 8'h00, 8'h11, 1);
        tick();
        checkOutput("st01_clears_valid", 16'(bus.RespValid), 16'h0);
        applyStimulus(1, 1, 8'h02, 8'h00, 8'h22, 1);
        tick();
        applyStimulus(1, 1, 8'h03, 8'h00, 8'h33, 1);
        tick();
        applyStimulus(1, 0, 8'h01, 8'h00, 8'h00, 1);
        tick();
        checkOutput("b2b1_valid", 16'(bus.RespValid), 16'h1);
        checkOutput("b2b1_data", 16'(bus.DataOut), 16'h11);
        applyStimulus(1, 0, 8'h02, 8'h00, 8'h00, 1);
        tick();
        checkOutput("b2b2_valid", 16'(bus.RespValid), 16'h1);
        checkOutput("b2b2_data", 16'(bus.DataOut), 16'h22);
        applyStimulus(1, 0, 8'h03, 8'h00, 8'h00, 1);
        tick();
        checkOutput("b2b3_valid", 16'(bus.RespValid), 16'h1);
        checkOutput("b2b3_data", 16'(bus.DataOut), 16'h33);
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 1);
        tick();
        checkOutput("b2b_end_valid", 16'(bus.RespValid), 16'h0);

        // Reset while a response is pending
        applyStimulus(1, 0, 8'h01, 8'h00, 8'h00, 0);
        tick();
        checkOutput("pend_valid", 16'(bus.RespValid), 16'h1);
        reset = 1'b1;
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 0);
        tick();
        checkOutput("rst2_valid", 16'(bus.RespValid), 16'h0);
        checkOutput("rst2_data", 16'(bus.DataOut), 16'h00);
        checkOutput("rst2_initdone", 16'(bus.InitDone), 16'h0);
        checkOutput("rst2_ready", 16'(bus.ReqReady), 16'h0);
        reset = 1'b0;

        // Reset again at sweep count 100; sweep must restart from 0
        for (int i = 0; i < 100; i++) tick();
        checkOutput("mid_initdone", 16'(bus.InitDone), 16'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        waitInitDone(n);
        checkOutput("reinit_cycles", 16'(n), 16'd256);

        // Word 01 was overwritten by the sweep
        applyStimulus(1, 0, 8'h01, 8'h00, 8'h00, 1);
        tick();
        checkOutput("reinit_data", 16'(bus.DataOut), 16'h5A);
        checkOutput("reinit_valid", 16'(bus.RespValid), 16'h1);
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
